// File: rtl/dp_elastic_pipe_pkg.sv
// dp_pkg: datapath payload layout shared by the elastic pipe and its users.
// Field offsets, widths and the packed payload struct.
package dp_pkg;

    localparam int DP_PAYLOAD_W = 101;

    localparam int DP_X_LSB    = 0;
    localparam int DP_NUM_LSB  = 32;
    localparam int DP_SUM_LSB  = 64;
    localparam int DP_OVF_BIT  = 96;
    localparam int DP_I_LSB    = 97;
    localparam int DP_I_W      = 3;
    localparam int DP_FLAG_BIT = 100;

    typedef struct packed {
        logic              flag_next;
        logic [DP_I_W-1:0] i;
        logic              overflow;
        logic [31:0]       sum;
        logic [31:0]       num;
        logic [31:0]       x;
    } dp_payload_t;

    function automatic dp_payload_t dp_pack(
        input logic [31:0]       x,
        input logic [31:0]       num,
        input logic [31:0]       sum,
        input logic              overflow,
        input logic [DP_I_W-1:0] i,
        input logic              flag_next
    );
        dp_payload_t p;
        p.x         = x;
        p.num       = num;
        p.sum       = sum;
        p.overflow  = overflow;
        p.i         = i;
        p.flag_next = flag_next;
        return p;
    endfunction

endpackage

// File: rtl/dp_elastic_pipe_if.sv
// dp_elastic_pipe_if: upstream and downstream valid/ready payload handshake.
// master drives the pipe (producer + consumer side), slave is the pipe.
interface dp_elastic_pipe_if
    import dp_pkg::*;
#(
    parameter int DATA_W = DP_PAYLOAD_W
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/dp_elastic_pipe_stage.sv
// dp_skid_stage: one two-entry (main + skid) elastic stage with flush.
// in_ready comes from local state only, so ready never chains combinationally.
module dp_skid_stage #(
    parameter int DATA_W = 101
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              accept;
    logic              pop;

    assign in_ready  = ~s_valid;
    assign accept    = in_valid & ~s_valid;
    assign pop       = m_valid & out_ready;
    assign out_valid = m_valid;
    assign out_data  = m_data;

    // Main entry refills from skid first (oldest), else from input; skid
    // catches the input only when main is occupied and not draining.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            s_valid <= 1'b0;
            s_data  <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else begin
            if (!m_valid || pop) begin
                if (s_valid) begin
                    m_data  <= s_data;
                    m_valid <= 1'b1;
                    s_valid <= 1'b0;
                end else if (accept) begin
                    m_data  <= in_data;
                    m_valid <= 1'b1;
                end else begin
                    m_valid <= 1'b0;
                end
            end
            if (m_valid && !pop && accept) begin
                s_data  <= in_data;
                s_valid <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/dp_elastic_pipe.sv
// dp_elastic_pipe: DEPTH chained skid stages carrying the datapath payload,
// with synchronous flush and a registered occupancy count.
module dp_elastic_pipe
    import dp_pkg::*;
#(
    parameter int DATA_W = DP_PAYLOAD_W,
    parameter int DEPTH  = 2,
    parameter int OCC_W  = $clog2(2*DEPTH+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    dp_elastic_pipe_if.slave bus,
    output logic [OCC_W-1:0] occupancy,
    output logic             full
);
    if (DEPTH < 1) begin : g_bad_depth
        $error("dp_elastic_pipe: DEPTH must be >= 1");
    end

    logic              v [DEPTH+1];
    logic              r [DEPTH+1];
    logic [DATA_W-1:0] d [DEPTH+1];
    logic              top_acc;
    logic              top_pop;

    // Gating stage0 valid with flush keeps the flush cycle from accepting.
    assign v[0]          = bus.in_valid & ~flush;
    assign d[0]          = bus.in_data;
    assign bus.in_ready  = r[0] & ~flush;
    assign r[DEPTH]      = bus.out_ready;
    assign bus.out_valid = v[DEPTH];
    assign bus.out_data  = d[DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        dp_skid_stage #(
            .DATA_W(DATA_W)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .in_valid (v[g]),
            .in_ready (r[g]),
            .in_data  (d[g]),
            .out_valid(v[g+1]),
            .out_ready(r[g+1]),
            .out_data (d[g+1])
        );
    end

    assign top_acc = bus.in_valid & bus.in_ready;
    assign top_pop = bus.out_valid & bus.out_ready;
    assign full    = (occupancy == OCC_W'(2*DEPTH));

    // Occupancy tracks entries in flight: +accept, -pop, zero on flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occupancy <= '0;
        end else if (flush) begin
            occupancy <= '0;
        end else begin
            occupancy <= occupancy + OCC_W'(top_acc) - OCC_W'(top_pop);
        end
    end
endmodule

// File: tb/tb_dp_elastic_pipe.sv
// tb_dp_elastic_pipe: directed + random checks of dp_elastic_pipe, DEPTH=2.
// Expected payloads come from mk(k), so order/loss/duplication are visible.
module tb_dp_elastic_pipe;
    import dp_pkg::*;

    localparam int DW    = DP_PAYLOAD_W;
    localparam int DEPTH = 2;
    localparam int OW    = $clog2(2*DEPTH+1);

    logic          clk;
    logic          rst;
    logic          flush;
    logic [OW-1:0] occupancy;
    logic          full;

    dp_elastic_pipe_if #(.DATA_W(DW)) bus();

    dp_elastic_pipe #(
        .DATA_W(DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .bus      (bus.slave),
        .occupancy(occupancy),
        .full     (full)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic          hs_rdy;
    logic          hs_acc;
    logic          hs_pop;
    logic [DW-1:0] hs_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: run did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] mk(input int unsigned k);
        logic [31:0] kk;
        kk = k;
        return dp_pack(kk, ~kk, kk * 3, kk[0], kk[2:0], kk[1]);
    endfunction

    // Sample handshakes mid-cycle, then step to just after the next edge.
    task automatic tick();
        @(negedge clk);
        hs_rdy  = bus.in_ready;
        hs_acc  = bus.in_valid && bus.in_ready;
        hs_pop  = bus.out_valid && bus.out_ready;
        hs_data = bus.out_data;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_out_valid: got %b want 0", bus.out_valid);
        end
        n_checks++;
        if (occupancy !== '0) begin
            n_fail++;
            $display("FAIL rst_occ: got %0d want 0", occupancy);
        end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_in_ready: got %b want 1", bus.in_ready);
        end
        n_checks++;
        if (full !== 1'b0 || bus.out_data !== '0) begin
            n_fail++;
            $display("FAIL rst_full_data: full %b data %h want 0/0",
                     full, bus.out_data);
        end
        rst = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = mk(1);
        tick();
        bus.in_valid = 1'b0;
        n_checks++;
        if (hs_acc !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL first_accept: acc %b out_valid %b want 1/0",
                     hs_acc, bus.out_valid);
        end
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data[31:0] !== 32'h1) begin
            n_fail++;
            $display("FAIL first_latency: valid %b x %h want 1/00000001",
                     bus.out_valid, bus.out_data[31:0]);
        end
        tick();
        n_checks++;
        if (hs_pop !== 1'b1 || hs_data !== mk(1) || occupancy !== '0) begin
            n_fail++;
            $display("FAIL first_pop: pop %b data %h occ %0d want 1/%h/0",
                     hs_pop, hs_data, occupancy, mk(1));
        end
    endtask

    task automatic test_stream();
        int pops = 0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 22; k++) begin
            bus.in_valid = (k < 20);
            bus.in_data  = mk(k);
            tick();
            n_checks++;
            if (hs_pop !== (k >= DEPTH)) begin
                n_fail++;
                $display("FAIL stream_bubble: tick %0d pop %b want %b",
                         k, hs_pop, (k >= DEPTH));
            end
            if (hs_pop) begin
                n_checks++;
                if (hs_data !== mk(pops)) begin
                    n_fail++;
                    $display("FAIL stream_data: got %h want %h",
                             hs_data, mk(pops));
                end
                pops++;
            end
            if (k >= 1 && k < 20) begin
                n_checks++;
                if (occupancy !== OW'(2)) begin
                    n_fail++;
                    $display("FAIL stream_occ: tick %0d got %0d want 2",
                             k, occupancy);
                end
            end
        end
        n_checks++;
        if (pops != 20 || occupancy !== '0) begin
            n_fail++;
            $display("FAIL stream_count: pops %0d occ %0d want 20/0",
                     pops, occupancy);
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        int pops = 0;
        int first_acc = -1;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = mk(100 + n);
            tick();
            if (hs_acc) n++;
        end
        n_checks++;
        if (n != 4) begin
            n_fail++;
            $display("FAIL bp_accepts: got %0d want 4", n);
        end
        n_checks++;
        if (bus.in_ready !== 1'b0 || full !== 1'b1 || occupancy !== OW'(4)) begin
            n_fail++;
            $display("FAIL bp_full: rdy %b full %b occ %0d want 0/1/4",
                     bus.in_ready, full, occupancy);
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 30 && (k < 8 || pops < n); k++) begin
            bus.in_valid = (k < 8);
            bus.in_data  = mk(100 + n);
            tick();
            if (k == 0) begin
                n_checks++;
                if (hs_pop !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bp_first_pop: got %b want 1", hs_pop);
                end
            end
            if (hs_acc) begin
                if (first_acc < 0) first_acc = k;
                n++;
            end
            if (hs_pop) begin
                n_checks++;
                if (hs_data !== mk(100 + pops)) begin
                    n_fail++;
                    $display("FAIL bp_order: got %h want %h",
                             hs_data, mk(100 + pops));
                end
                pops++;
            end
        end
        n_checks++;
        if (first_acc < 0 || first_acc > DEPTH) begin
            n_fail++;
            $display("FAIL bp_resume: first accept tick %0d want 0..%0d",
                     first_acc, DEPTH);
        end
        n_checks++;
        if (pops != n || n <= 4 || occupancy !== '0) begin
            n_fail++;
            $display("FAIL bp_drain: pops %0d accepts %0d occ %0d",
                     pops, n, occupancy);
        end
    endtask

    task automatic test_random();
        int sent = 0;
        int pops = 0;
        for (int t = 0; t < 20000 && pops < 1000; t++) begin
            bus.in_valid  = (sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.in_data   = mk(5000 + sent);
            bus.out_ready = 1'($urandom_range(0, 1));
            tick();
            if (hs_acc) sent++;
            if (hs_pop) begin
                n_checks++;
                if (hs_data !== mk(5000 + pops)) begin
                    n_fail++;
                    $display("FAIL rand_item %0d: got %h want %h",
                             pops, hs_data, mk(5000 + pops));
                end
                pops++;
            end
        end
        n_checks++;
        if (sent != 1000 || pops != 1000 || occupancy !== '0) begin
            n_fail++;
            $display("FAIL rand_count: sent %0d pops %0d occ %0d want 1000/1000/0",
                     sent, pops, occupancy);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_flush();
        int n = 0;
        int pops = 0;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = mk(200 + k);
            tick();
        end
        n_checks++;
        if (occupancy !== OW'(3)) begin
            n_fail++;
            $display("FAIL flush_setup_occ: got %0d want 3", occupancy);
        end
        flush         = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = mk(300);
        tick();
        flush = 1'b0;
        n_checks++;
        if (hs_rdy !== 1'b0 || hs_acc !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_ready: rdy %b acc %b want 0/0", hs_rdy, hs_acc);
        end
        n_checks++;
        if (hs_pop !== 1'b1 || hs_data !== mk(200)) begin
            n_fail++;
            $display("FAIL flush_head: pop %b data %h want 1/%h",
                     hs_pop, hs_data, mk(200));
        end
        n_checks++;
        if (occupancy !== '0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_clear: occ %0d out_valid %b want 0/0",
                     occupancy, bus.out_valid);
        end
        for (int k = 0; k < 20 && pops < 5; k++) begin
            bus.in_valid = (n < 5);
            bus.in_data  = mk(300 + n);
            tick();
            if (hs_acc) n++;
            if (hs_pop) begin
                n_checks++;
                if (hs_data !== mk(300 + pops)) begin
                    n_fail++;
                    $display("FAIL flush_after: got %h want %h",
                             hs_data, mk(300 + pops));
                end
                pops++;
            end
        end
        n_checks++;
        if (pops != 5) begin
            n_fail++;
            $display("FAIL flush_after_count: got %0d want 5", pops);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        int n = 0;
        int pops = 0;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = mk(400 + k);
            tick();
        end
        n_checks++;
        if (occupancy !== OW'(4) || full !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_setup: occ %0d full %b want 4/1", occupancy, full);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || occupancy !== '0 || full !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_immediate: valid %b occ %0d full %b want 0/0/0",
                     bus.out_valid, occupancy, full);
        end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_in_ready: got %b want 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 20 && pops < 5; k++) begin
            bus.in_valid = (n < 5);
            bus.in_data  = mk(500 + n);
            tick();
            if (k == 0) begin
                n_checks++;
                if (hs_acc !== 1'b1) begin
                    n_fail++;
                    $display("FAIL arst_first_accept: got %b want 1", hs_acc);
                end
            end
            if (hs_acc) n++;
            if (hs_pop) begin
                n_checks++;
                if (hs_data !== mk(500 + pops)) begin
                    n_fail++;
                    $display("FAIL arst_stale: got %h want %h",
                             hs_data, mk(500 + pops));
                end
                pops++;
            end
        end
        n_checks++;
        if (pops != 5 || occupancy !== '0) begin
            n_fail++;
            $display("FAIL arst_after_count: pops %0d occ %0d want 5/0",
                     pops, occupancy);
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_random();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
